// File: rtl/gray_read_controller.sv
// Debounced read sequencer for the Gray decoder path; GRAY_READ_AUTO_REFRESH_EN adds periodic requests.
// Latency: req in cycle t -> read_out at t+1, dbin_out/strobe_out at t+3+DECODE_LAT.
// Backpressure: one request queued while busy, further requests dropped.
module gray_read_controller #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int DECODE_LAT      = 3,
  parameter int DATA_W          = 4,
  parameter int REFRESH_CYCLES  = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_read,
  input  logic [DATA_W-1:0] dbin_in,
  output logic              read_out,
  output logic [DATA_W-1:0] dbin_out,
  output logic              valid_out,
  output logic              strobe_out,
  output logic              busy_out
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam int WW = $clog2(DECODE_LAT + 1);
  localparam logic [WW-1:0] W_LOAD = WW'(DECODE_LAT);
  localparam logic [WW-1:0] W_ONE  = WW'(1);

  typedef enum logic [1:0] {IDLE, SAMPLE, WAIT, LATCH} state_t;

  state_t          state, state_n;
  logic            sync1, sync2;
  logic            deb_lvl, deb_prev;
  logic [DBW-1:0]  deb_cnt;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic            pending, pend_n;
  logic            req_btn, req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_read;
      sync2 <= sync1;
    end
  end

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_lvl  <= 1'b0;
      deb_prev <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      deb_prev <= deb_lvl;
      if (sync2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_LAST) begin
        deb_lvl <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign req_btn = deb_lvl & ~deb_prev;

`ifdef GRAY_READ_AUTO_REFRESH_EN
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_CYCLES - 1);

  logic [RW-1:0] ref_cnt;
  logic          ref_wrap;

  assign ref_wrap = (ref_cnt == R_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
    end else if (ref_wrap) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign req = req_btn | ref_wrap;
`else
  assign req = req_btn;

  // Refresh period has no effect without auto-refresh.
  if (REFRESH_CYCLES < 1) begin : g_refresh_unused
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      pending    <= 1'b0;
      dbin_out   <= '0;
      valid_out  <= 1'b0;
      strobe_out <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_n;
      pending    <= pend_n;
      strobe_out <= (state == LATCH);
      if (state == LATCH) begin
        dbin_out  <= dbin_in;
        valid_out <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    pend_n  = pending;
    case (state)
      IDLE: begin
        pend_n = 1'b0;
        if (req || pending) state_n = SAMPLE;
      end
      SAMPLE: begin
        wait_n  = W_LOAD;
        state_n = WAIT;
        if (req) pend_n = 1'b1;
      end
      WAIT: begin
        wait_n = wait_cnt - 1'b1;
        if (wait_cnt == W_ONE) state_n = LATCH;
        if (req) pend_n = 1'b1;
      end
      LATCH: begin
        // A queued request wins; a fresh one arriving here is queued for IDLE.
        if (pending) begin
          state_n = SAMPLE;
          pend_n  = 1'b0;
        end else begin
          state_n = IDLE;
          pend_n  = req;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign read_out = (state == SAMPLE);
  assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_gray_read_controller.sv
// Directed bench for gray_read_controller (DEBOUNCE_CYCLES=4, DECODE_LAT=3); a second
// instance with a long decode latency leaves room for a debounced press during WAIT.
module tb_gray_read_controller;
  localparam int DW = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          btn_read = 1'b1;
  logic [DW-1:0] dbin_in  = '0;

  logic          read_out, valid_out, strobe_out, busy_out;
  logic [DW-1:0] dbin_out;
  logic          q_read_out, q_valid_out, q_strobe_out, q_busy_out;
  logic [DW-1:0] q_dbin_out;

  int checks = 0;
  int errors = 0;
  int n_read = 0, n_strobe = 0, nq_read = 0, nq_strobe = 0;

  always #5 clk = ~clk;

  gray_read_controller #(
    .DEBOUNCE_CYCLES(4), .DECODE_LAT(3), .DATA_W(DW), .REFRESH_CYCLES(20)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_read(btn_read), .dbin_in(dbin_in),
    .read_out(read_out), .dbin_out(dbin_out), .valid_out(valid_out),
    .strobe_out(strobe_out), .busy_out(busy_out)
  );

  gray_read_controller #(
    .DEBOUNCE_CYCLES(4), .DECODE_LAT(16), .DATA_W(DW), .REFRESH_CYCLES(20)
  ) u_dut_q (
    .clk(clk), .rst_n(rst_n), .btn_read(btn_read), .dbin_in(dbin_in),
    .read_out(q_read_out), .dbin_out(q_dbin_out), .valid_out(q_valid_out),
    .strobe_out(q_strobe_out), .busy_out(q_busy_out)
  );

  always @(negedge clk) begin
    if (read_out)     n_read++;
    if (strobe_out)   n_strobe++;
    if (q_read_out)   nq_read++;
    if (q_strobe_out) nq_strobe++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    btn_read = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int  b_read, b_strobe;
    logic e;
    rst_n    = 1'b0;
    btn_read = 1'b1;
    dbin_in  = '0;
    repeat (3) tick();
    checks++;
    if ({read_out, valid_out, strobe_out, busy_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {read_out, valid_out, strobe_out, busy_out});
    end
    checks++;
    if (dbin_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_dbin: got %b expected 0000", dbin_out);
    end
    b_read   = n_read;
    b_strobe = n_strobe;
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      e = (k == 7);
      checks++;
      if (read_out !== e) begin
        errors++;
        $display("FAIL rst_release_read k=%0d: got %b expected %b", k, read_out, e);
      end
      e = (k == 12);
      checks++;
      if (strobe_out !== e) begin
        errors++;
        $display("FAIL rst_release_strobe k=%0d: got %b expected %b", k, strobe_out, e);
      end
      e = (k >= 7 && k <= 11);
      checks++;
      if (busy_out !== e) begin
        errors++;
        $display("FAIL rst_release_busy k=%0d: got %b expected %b", k, busy_out, e);
      end
    end
    repeat (20) tick();
    checks++;
    if (n_read - b_read != 1) begin
      errors++;
      $display("FAIL held_button_reads: got %0d expected 1", n_read - b_read);
    end
    checks++;
    if (n_strobe - b_strobe != 1) begin
      errors++;
      $display("FAIL held_button_strobes: got %0d expected 1", n_strobe - b_strobe);
    end
    checks++;
    if (valid_out !== 1'b1) begin
      errors++;
      $display("FAIL held_button_valid: got %b expected 1", valid_out);
    end
    btn_read = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_single_read();
    logic          e;
    logic [DW-1:0] ed;
    apply_reset();
    dbin_in  = 4'b1011;
    btn_read = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      e = (k == 7);
      checks++;
      if (read_out !== e) begin
        errors++;
        $display("FAIL single_read k=%0d: got %b expected %b", k, read_out, e);
      end
      e = (k == 12);
      checks++;
      if (strobe_out !== e) begin
        errors++;
        $display("FAIL single_strobe k=%0d: got %b expected %b", k, strobe_out, e);
      end
      e = (k >= 12);
      checks++;
      if (valid_out !== e) begin
        errors++;
        $display("FAIL single_valid k=%0d: got %b expected %b", k, valid_out, e);
      end
      ed = (k >= 12) ? 4'b1011 : 4'b0000;
      checks++;
      if (dbin_out !== ed) begin
        errors++;
        $display("FAIL single_dbin k=%0d: got %b expected %b", k, dbin_out, ed);
      end
      if (k == 10) btn_read = 1'b0;
    end
  endtask

  task automatic test_bounce();
    int b_read;
    apply_reset();
    dbin_in = 4'b1011;
    b_read  = n_read;
    for (int i = 0; i < 10; i++) begin
      btn_read = ((i % 2) == 0);
      repeat (2) tick();
    end
    btn_read = 1'b0;
    repeat (20) tick();
    checks++;
    if (n_read != b_read) begin
      errors++;
      $display("FAIL bounce_reads: got %0d expected 0", n_read - b_read);
    end
    checks++;
    if (dbin_out !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_dbin: got %b expected 0000", dbin_out);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL bounce_valid: got %b expected 0", valid_out);
    end
  endtask

  // Presses (4 cycles each) start at ticks 0, 8, 16: reqs at 6 (run), 14 (queued), 22 (dropped).
  task automatic test_queued();
    int b_qr, b_qs, b_s;
    apply_reset();
    dbin_in = 4'b1001;
    b_qr = nq_read;
    b_qs = nq_strobe;
    b_s  = n_strobe;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) tick();
      if (k >= 7 && k <= 42) begin
        checks++;
        if (q_busy_out !== 1'b1) begin
          errors++;
          $display("FAIL queued_busy k=%0d: got %b expected 1", k, q_busy_out);
        end
      end
      if (k == 25) begin
        checks++;
        if ({q_read_out, q_strobe_out} !== 2'b11) begin
          errors++;
          $display("FAIL queued_back_to_back: got read/strobe %b expected 11", {q_read_out, q_strobe_out});
        end
      end
      if (k == 43) begin
        checks++;
        if ({q_busy_out, q_strobe_out} !== 2'b01) begin
          errors++;
          $display("FAIL queued_second_done: got busy/strobe %b expected 01", {q_busy_out, q_strobe_out});
        end
        checks++;
        if (q_dbin_out !== 4'b1001) begin
          errors++;
          $display("FAIL queued_dbin: got %b expected 1001", q_dbin_out);
        end
      end
      btn_read = (k < 4) || (k >= 8 && k < 12) || (k >= 16 && k < 20);
    end
    tick();
    checks++;
    if (nq_read - b_qr != 2) begin
      errors++;
      $display("FAIL queued_reads: got %0d expected 2", nq_read - b_qr);
    end
    checks++;
    if (nq_strobe - b_qs != 2) begin
      errors++;
      $display("FAIL queued_strobes: got %0d expected 2", nq_strobe - b_qs);
    end
    checks++;
    if (q_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL queued_valid: got %b expected 1", q_valid_out);
    end
    checks++;
    if (n_strobe - b_s != 3) begin
      errors++;
      $display("FAIL short_lat_strobes: got %0d expected 3", n_strobe - b_s);
    end
  endtask

  task automatic test_reset_midop();
    int b_s;
    apply_reset();
    dbin_in  = 4'b0110;
    btn_read = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 4) btn_read = 1'b0;
    end
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("FAIL midop_busy_before: got %b expected 1", busy_out);
    end
    b_s   = n_strobe;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({read_out, busy_out, strobe_out} !== 3'b000) begin
      errors++;
      $display("FAIL midop_async_clear: got %b expected 000", {read_out, busy_out, strobe_out});
    end
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (n_strobe != b_s) begin
      errors++;
      $display("FAIL midop_strobes: got %0d expected 0", n_strobe - b_s);
    end
    checks++;
    if ({dbin_out, valid_out, busy_out} !== 6'b000000) begin
      errors++;
      $display("FAIL midop_state: got dbin/valid/busy %b expected 000000", {dbin_out, valid_out, busy_out});
    end
  endtask

`ifdef GRAY_READ_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    logic e;
    rst_n    = 1'b0;
    btn_read = 1'b0;
    dbin_in  = 4'b0101;
    repeat (3) tick();
    checks++;
    if ({read_out, busy_out, valid_out} !== 3'b000) begin
      errors++;
      $display("FAIL refresh_reset: got %b expected 000", {read_out, busy_out, valid_out});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      tick();
      e = (k == 20 || k == 40 || k == 60);
      checks++;
      if (read_out !== e) begin
        errors++;
        $display("FAIL refresh_read k=%0d: got %b expected %b", k, read_out, e);
      end
      if (k == 25) begin
        checks++;
        if ({strobe_out, dbin_out} !== 5'b1_0101) begin
          errors++;
          $display("FAIL refresh_first: got strobe/dbin %b expected 10101", {strobe_out, dbin_out});
        end
      end
      if (k == 30) dbin_in = 4'b1100;
      if (k == 45) begin
        checks++;
        if ({strobe_out, dbin_out} !== 5'b1_1100) begin
          errors++;
          $display("FAIL refresh_second: got strobe/dbin %b expected 11100", {strobe_out, dbin_out});
        end
      end
    end
  endtask
`endif

  initial begin
`ifdef GRAY_READ_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_reset();
    test_single_read();
    test_bounce();
    test_queued();
    test_reset_midop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_read_controller.md
Name: gray_read_controller

Overview:
- Sequences the Gray-to-binary read path.
- Debounces the raw read push-button and issues a single-cycle read pulse to the switch-sync/decoder datapath.
- Waits out the datapath latency, then latches the decoded 4-bit value with valid/strobe flags for display logic.
- Sits between board I/O and the Gray decoder submodule, one instance per decoder.

Parameters:
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a new button level (min 2).
- DECODE_LAT, 3, cycles from read pulse to valid decoder output (min 1).
- DATA_W, 4, width of the decoded binary word.
- REFRESH_CYCLES, 50000000, auto-refresh period; used only with AUTO_REFRESH_EN.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_read  input  1  raw, asynchronous, bouncy read button.
- dbin_in  input  DATA_W  binary output of the Gray decoder datapath.
- read_out  output  1  single-cycle read pulse to the switch sync stage.
- dbin_out  output  DATA_W  latched decoded value.
- valid_out  output  1  sticky: at least one conversion completed since reset.
- strobe_out  output  1  one-cycle pulse when dbin_out updates.
- busy_out  output  1  conversion in progress.

Behaviour:
- Reset is asynchronous and active-low. Assertion forces:
  - FSM to IDLE.
  - read_out, dbin_out, valid_out, strobe_out, busy_out to 0.
  - Synchronizer flops, debounced level, debounce counter, wait counter and pending flag to 0.
- Reset mid-conversion aborts with no latch. After release, the first request needs a full debounce.
- Input conditioning:
  - btn_read passes through a 2-flop synchronizer.
  - The debounce counter resets whenever the synchronized level equals the debounced level or changes.
  - The debounced level updates when the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - A rising edge of the debounced level produces a one-cycle internal request (req).
  - A held button produces exactly one req. Pulses shorter than DEBOUNCE_CYCLES produce none.
- FSM states are IDLE, SAMPLE, WAIT, LATCH.
  - IDLE: on req or pending, go to SAMPLE and clear pending.
  - SAMPLE: read_out=1 for exactly this cycle; load wait counter with DECODE_LAT; go to WAIT.
  - WAIT: decrement each cycle; after DECODE_LAT cycles in WAIT, go to LATCH.
  - LATCH: capture dbin_in into dbin_out at the end of this cycle.
    - Next cycle: strobe_out=1 for one cycle and valid_out=1 (held until reset).
    - FSM goes to SAMPLE if pending is set, else IDLE.
- busy_out = 1 in SAMPLE, WAIT and LATCH.
- Latency: req high in cycle t gives read_out in t+1 and dbin_out/strobe_out visible in t+3+DECODE_LAT.
- Requests while busy:
  - One request is queued in pending and serviced back-to-back from LATCH.
  - Further requests while pending is set are dropped.
  - req arriving in the same cycle as the LATCH to IDLE transition is queued, not lost.
- dbin_out is unchanged except in the LATCH update; DATA_W bits are copied verbatim with no arithmetic.

Optional Feature:
- Macro: GRAY_READ_AUTO_REFRESH_EN.
- When defined:
  - A free-running counter counts 0..REFRESH_CYCLES-1 and wraps to 0.
  - The wrap cycle raises an internal request identical to req, including pending/drop rules.
  - The button path remains active; a button request and a refresh request in the same cycle count as one request.
  - The counter resets to 0 on rst_n.
- When undefined: the counter logic is absent and only the button starts conversions; REFRESH_CYCLES is ignored.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, DECODE_LAT=3.
- Reset: assert rst_n=0 with btn_read=1 → all outputs 0. Release with the button held → one conversion, starting after 2 sync + 4 stable cycles.
- Single read: dbin_in=4'b1011, clean press held 10 cycles → one read_out pulse. strobe_out fires 6 cycles after req, with dbin_out=4'b1011 and valid_out=1 thereafter.
- Bounce rejection: btn_read toggles every 2 cycles for 20 cycles, then settles at 0 → no read_out and dbin_out stays 0.
- Queued request: second debounced press while in WAIT → second SAMPLE immediately follows the first LATCH with busy_out continuously 1. A third press during that window is dropped: exactly 2 strobes total.
- Reset mid-op: rst_n pulsed low while in WAIT with dbin_in=4'b0110 → no strobe, dbin_out=0, valid_out=0, FSM in IDLE.
- With GRAY_READ_AUTO_REFRESH_EN, REFRESH_CYCLES=20 and no button → read_out every 20 cycles. dbin_in changed 0101→1100 → dbin_out follows on the next strobe.
